// File: rtl/sync_fifo_wconv.sv
// Single-clock FIFO that packs RATIO consecutive WR_W-bit writes into one RD_W-bit read word.
// Storage is RATIO parallel banks; occupancy and flags are registered from the next-state count.
module sync_fifo_wconv #(
   parameter int WR_W      = 8,
   parameter int RATIO     = 2,
   parameter int DEPTH     = 256,
   parameter int MSB_FIRST = 0,
   parameter int AFULL_TH  = 240
) (
   input  logic                              sys_clk,
   input  logic                              sys_rst,
   input  logic                              wr_req,
   input  logic [WR_W-1:0]                   wr_data,
   input  logic                              rd_req,
   output logic [WR_W*RATIO-1:0]             rd_data,
   output logic                              empty,
   output logic                              full,
   output logic                              almost_full,
   output logic [$clog2(DEPTH):0]            wr_usedw,
   output logic [$clog2(DEPTH/RATIO):0]      rd_usedw,
   output logic                              overflow,
   output logic                              underflow
);
   localparam int AW     = $clog2(DEPTH);
   localparam int LR     = $clog2(RATIO);
   localparam int BANK_D = DEPTH / RATIO;
   localparam int EW     = $clog2(BANK_D);

   localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
   localparam logic [AW:0]   RATIO_C   = (AW+1)'(RATIO);
   localparam logic [AW:0]   AFULL_C   = (AW+1)'(AFULL_TH);
   localparam logic [AW-1:0] BANK_MASK = AW'(RATIO - 1);

   logic [AW:0]     wr_ptr_reg;
   logic [EW:0]     rd_ptr_reg;
   logic [AW:0]     count_reg;
   logic [AW:0]     count_next;
   logic            full_reg;
   logic            empty_reg;
   logic            afull_reg;
   logic            overflow_reg;
   logic            underflow_reg;
   logic            wr_acc;
   logic            rd_acc;
   logic [WR_W-1:0] bank_q [RATIO];

   // Pointer MSBs only mark wrap parity; full/empty come from the count instead.
   logic unused_ptr_msbs;
   assign unused_ptr_msbs = wr_ptr_reg[AW] ^ rd_ptr_reg[EW];

   assign wr_acc = wr_req & ~full_reg;
   assign rd_acc = rd_req & ~empty_reg;

   always_comb begin
      count_next = count_reg;
      if (wr_acc)
         count_next = count_next + (AW+1)'(1);
      if (rd_acc)
         count_next = count_next - RATIO_C;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         full_reg      <= 1'b0;
         empty_reg     <= 1'b1;
         afull_reg     <= 1'b0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         if (wr_acc)
            wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
         if (rd_acc)
            rd_ptr_reg <= rd_ptr_reg + (EW+1)'(1);
         count_reg     <= count_next;
         full_reg      <= (count_next == DEPTH_C);
         empty_reg     <= (count_next < RATIO_C);
         afull_reg     <= (count_next >= AFULL_C);
         overflow_reg  <= wr_req & full_reg;
         underflow_reg <= rd_req & empty_reg;
      end
   end

   // Write pointer low bits pick the bank, so bank k always holds the k-th word of a group.
   genvar gi;
   generate
      for (gi = 0; gi < RATIO; gi = gi + 1) begin : g_bank
         logic [WR_W-1:0] mem [BANK_D];
         logic [WR_W-1:0] q_reg;
         logic            wr_en;

         assign wr_en = wr_acc && ((wr_ptr_reg[AW-1:0] & BANK_MASK) == AW'(gi));

         always_ff @(posedge sys_clk) begin
            if (wr_en)
               mem[wr_ptr_reg[AW-1:LR]] <= wr_data;
         end

         always_ff @(posedge sys_clk) begin
            if (sys_rst)
               q_reg <= '0;
            else if (rd_acc)
               q_reg <= mem[rd_ptr_reg[EW-1:0]];
         end

         assign bank_q[gi] = q_reg;
      end
   endgenerate

   always_comb begin
      rd_data = '0;
      for (int k = 0; k < RATIO; k++) begin
         if (MSB_FIRST != 0)
            rd_data[(RATIO-1-k)*WR_W +: WR_W] = bank_q[k];
         else
            rd_data[k*WR_W +: WR_W] = bank_q[k];
      end
   end

   assign empty       = empty_reg;
   assign full        = full_reg;
   assign almost_full = afull_reg;
   assign wr_usedw    = count_reg;
   assign rd_usedw    = count_reg[AW:LR];
   assign overflow    = overflow_reg;
   assign underflow   = underflow_reg;
endmodule

// File: tb/tb_sync_fifo_wconv.sv
// Directed bench for sync_fifo_wconv: two instances (LSB-first and MSB-first packing) share stimulus.
module tb_sync_fifo_wconv;
   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        wr_req  = 1'b0;
   logic [7:0]  wr_data = 8'h00;
   logic        rd_req  = 1'b0;

   logic [15:0] rd_data;
   logic        empty, full, almost_full, overflow, underflow;
   logic [8:0]  wr_usedw;
   logic [7:0]  rd_usedw;

   logic [15:0] m_rd_data;
   logic        m_empty, m_full, m_almost_full, m_overflow, m_underflow;
   logic [8:0]  m_wr_usedw;
   logic [7:0]  m_rd_usedw;

   int vectors    = 0;
   int miscompares = 0;

   always #5 sys_clk = ~sys_clk;

   sync_fifo_wconv #(.WR_W(8), .RATIO(2), .DEPTH(256), .MSB_FIRST(0), .AFULL_TH(240)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_req(wr_req), .wr_data(wr_data),
      .rd_req(rd_req), .rd_data(rd_data), .empty(empty), .full(full),
      .almost_full(almost_full), .wr_usedw(wr_usedw), .rd_usedw(rd_usedw),
      .overflow(overflow), .underflow(underflow));

   sync_fifo_wconv #(.WR_W(8), .RATIO(2), .DEPTH(256), .MSB_FIRST(1), .AFULL_TH(240)) dut_m (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_req(wr_req), .wr_data(wr_data),
      .rd_req(rd_req), .rd_data(m_rd_data), .empty(m_empty), .full(m_full),
      .almost_full(m_almost_full), .wr_usedw(m_wr_usedw), .rd_usedw(m_rd_usedw),
      .overflow(m_overflow), .underflow(m_underflow));

   // Inputs change just after a falling edge; outputs are sampled at the next falling edge.
   task automatic do_write(input logic [7:0] d);
      wr_req  = 1'b1;
      wr_data = d;
      @(negedge sys_clk);
      wr_req  = 1'b0;
   endtask

   task automatic do_read();
      rd_req = 1'b1;
      @(negedge sys_clk);
      rd_req = 1'b0;
   endtask

   task automatic test_reset();
      sys_rst = 1'b1; wr_req = 1'b1; rd_req = 1'b1; wr_data = 8'hEE;
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
      vectors++;
      if ({empty, full, almost_full, overflow, underflow} !== 5'b10000) begin
         miscompares++;
         $display("FAIL reset_flags: got e/f/af/ov/un=%b expected 10000", {empty, full, almost_full, overflow, underflow});
      end
      vectors++;
      if (wr_usedw !== 9'd0 || rd_usedw !== 8'd0) begin
         miscompares++;
         $display("FAIL reset_usedw: got wr=%0d rd=%0d expected 0 0", wr_usedw, rd_usedw);
      end
      vectors++;
      if (rd_data !== 16'h0000 || m_rd_data !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_rd_data: got %h/%h expected 0000/0000", rd_data, m_rd_data);
      end
      $display("reset: e=%b f=%b wr_usedw=%0d rd_data=%h", empty, full, wr_usedw, rd_data);
   endtask

   task automatic test_packing();
      do_write(8'h11);
      do_write(8'h22);
      vectors++;
      if (empty !== 1'b0 || rd_usedw !== 8'd1) begin
         miscompares++;
         $display("FAIL pack_ready: got empty=%b rd_usedw=%0d expected 0 1", empty, rd_usedw);
      end
      do_read();
      vectors++;
      if (rd_data !== 16'h2211) begin
         miscompares++;
         $display("FAIL pack_lsb_first: got %h expected 2211", rd_data);
      end
      vectors++;
      if (m_rd_data !== 16'h1122) begin
         miscompares++;
         $display("FAIL pack_msb_first: got %h expected 1122", m_rd_data);
      end
      vectors++;
      if (wr_usedw !== 9'd0 || empty !== 1'b1) begin
         miscompares++;
         $display("FAIL pack_after_read: got wr_usedw=%0d empty=%b expected 0 1", wr_usedw, empty);
      end
      $display("packing: lsb=%h msb=%h", rd_data, m_rd_data);
   endtask

   task automatic test_partial();
      do_write(8'hAA);
      vectors++;
      if (wr_usedw !== 9'd1 || rd_usedw !== 8'd0 || empty !== 1'b1) begin
         miscompares++;
         $display("FAIL partial_one: got wr=%0d rd=%0d empty=%b expected 1 0 1", wr_usedw, rd_usedw, empty);
      end
      do_read();
      vectors++;
      if (underflow !== 1'b1 || rd_data !== 16'h2211) begin
         miscompares++;
         $display("FAIL partial_underflow: got un=%b rd_data=%h expected 1 2211", underflow, rd_data);
      end
      @(negedge sys_clk);
      vectors++;
      if (underflow !== 1'b0 || wr_usedw !== 9'd1) begin
         miscompares++;
         $display("FAIL partial_pulse: got un=%b wr_usedw=%0d expected 0 1", underflow, wr_usedw);
      end
      do_write(8'hBB);
      vectors++;
      if (empty !== 1'b0 || rd_usedw !== 8'd1) begin
         miscompares++;
         $display("FAIL partial_complete: got empty=%b rd_usedw=%0d expected 0 1", empty, rd_usedw);
      end
      do_read();
      vectors++;
      if (rd_data !== 16'hBBAA) begin
         miscompares++;
         $display("FAIL partial_data: got %h expected bbaa", rd_data);
      end
      $display("partial: rd_data=%h", rd_data);
   endtask

   task automatic test_fill_drain();
      logic [15:0] exp;
      for (int i = 0; i < 256; i++) begin
         do_write(8'(i));
         vectors++;
         if (almost_full !== (i + 1 >= 240) || wr_usedw !== 9'(i + 1)) begin
            miscompares++;
            $display("FAIL fill_step%0d: got af=%b wr_usedw=%0d expected %b %0d", i, almost_full, wr_usedw, (i + 1 >= 240), i + 1);
         end
      end
      vectors++;
      if (full !== 1'b1 || wr_usedw !== 9'd256 || rd_usedw !== 8'd128) begin
         miscompares++;
         $display("FAIL fill_full: got full=%b wr=%0d rd=%0d expected 1 256 128", full, wr_usedw, rd_usedw);
      end
      do_write(8'h99);
      vectors++;
      if (overflow !== 1'b1 || wr_usedw !== 9'd256 || full !== 1'b1) begin
         miscompares++;
         $display("FAIL fill_overflow: got ov=%b wr=%0d full=%b expected 1 256 1", overflow, wr_usedw, full);
      end
      // Write + read at full: write still rejected by the pre-edge full flag.
      wr_req = 1'b1; wr_data = 8'h77; rd_req = 1'b1;
      @(negedge sys_clk);
      wr_req = 1'b0; rd_req = 1'b0;
      vectors++;
      if (overflow !== 1'b1 || rd_data !== 16'h0100 || wr_usedw !== 9'd254 || full !== 1'b0) begin
         miscompares++;
         $display("FAIL full_simul: got ov=%b rd_data=%h wr=%0d full=%b expected 1 0100 254 0", overflow, rd_data, wr_usedw, full);
      end
      $display("full_simul: rd_data=%h wr_usedw=%0d", rd_data, wr_usedw);
      for (int i = 1; i < 128; i++) begin
         do_read();
         exp = {8'(2 * i + 1), 8'(2 * i)};
         vectors++;
         if (rd_data !== exp) begin
            miscompares++;
            $display("FAIL drain%0d: got %h expected %h", i, rd_data, exp);
         end
      end
      vectors++;
      if (empty !== 1'b1 || wr_usedw !== 9'd0 || almost_full !== 1'b0) begin
         miscompares++;
         $display("FAIL drain_empty: got empty=%b wr=%0d af=%b expected 1 0 0", empty, wr_usedw, almost_full);
      end
      $display("fill_drain: last rd_data=%h", rd_data);
   endtask

   task automatic test_simultaneous();
      for (int i = 1; i <= 4; i++)
         do_write(8'(i));
      wr_req = 1'b1; wr_data = 8'h05; rd_req = 1'b1;
      @(negedge sys_clk);
      wr_req = 1'b0; rd_req = 1'b0;
      vectors++;
      if (wr_usedw !== 9'd3 || rd_data !== 16'h0201) begin
         miscompares++;
         $display("FAIL simul_mid: got wr=%0d rd_data=%h expected 3 0201", wr_usedw, rd_data);
      end
      do_read();
      vectors++;
      if (rd_data !== 16'h0403 || wr_usedw !== 9'd1 || empty !== 1'b1) begin
         miscompares++;
         $display("FAIL simul_tail: got rd_data=%h wr=%0d empty=%b expected 0403 1 1", rd_data, wr_usedw, empty);
      end
      do_write(8'h06);
      do_read();
      vectors++;
      if (rd_data !== 16'h0605 || wr_usedw !== 9'd0) begin
         miscompares++;
         $display("FAIL simul_last: got rd_data=%h wr=%0d expected 0605 0", rd_data, wr_usedw);
      end
      $display("simultaneous: rd_data=%h", rd_data);
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp;
      for (int i = 0; i < 256; i++)
         do_write(8'(i) ^ 8'h5A);
      vectors++;
      if (full !== 1'b1) begin
         miscompares++;
         $display("FAIL wrap_full: got full=%b expected 1", full);
      end
      for (int i = 0; i < 128; i++) begin
         do_read();
         exp = {8'(2 * i + 1) ^ 8'h5A, 8'(2 * i) ^ 8'h5A};
         vectors++;
         if (rd_data !== exp) begin
            miscompares++;
            $display("FAIL wrap_drain%0d: got %h expected %h", i, rd_data, exp);
         end
      end
      vectors++;
      if (empty !== 1'b1 || wr_usedw !== 9'd0) begin
         miscompares++;
         $display("FAIL wrap_empty: got empty=%b wr=%0d expected 1 0", empty, wr_usedw);
      end
      $display("back_to_back: last rd_data=%h", rd_data);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 10; i++)
         do_write(8'hC0 + 8'(i));
      sys_rst = 1'b1;
      @(negedge sys_clk);
      sys_rst = 1'b0;
      vectors++;
      if (wr_usedw !== 9'd0 || rd_usedw !== 8'd0 || empty !== 1'b1 || rd_data !== 16'h0000) begin
         miscompares++;
         $display("FAIL rst_mid: got wr=%0d rd=%0d empty=%b rd_data=%h expected 0 0 1 0000", wr_usedw, rd_usedw, empty, rd_data);
      end
      do_write(8'h5A);
      do_write(8'hA5);
      do_read();
      vectors++;
      if (rd_data !== 16'hA55A || empty !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_mid_data: got rd_data=%h empty=%b expected a55a 1", rd_data, empty);
      end
      $display("reset_mid: rd_data=%h", rd_data);
   endtask

   initial begin
      test_reset();
      test_packing();
      test_partial();
      test_fill_drain();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
